// File: rtl/debug_unit_pkg.sv
// Shared definitions for the UART debug unit: host command bytes, the HALT
// encoding that ends a program load, and the controller state enum.
package debug_pkg;

    localparam logic [7:0]  CMD_LOAD   = 8'h4C;  // 'L'
    localparam logic [7:0]  CMD_CONT   = 8'h43;  // 'C'
    localparam logic [7:0]  CMD_STEP   = 8'h53;  // 'S'
    localparam logic [31:0] HALT_INSTR = 32'h0000_003F;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LOAD_WR,
        RUN,
        STEP,
        DUMP_ADDR,
        DUMP_CAP,
        DUMP_SEND,
        DUMP_WAIT
    } state_e;

endpackage

// File: rtl/debug_word_tx.sv
// Word-to-byte serializer: holds one captured word and presents it MSB byte
// first, advancing one byte per completed transmitter handshake.
module debug_word_tx #(
    parameter int INST_SZ = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [INST_SZ-1:0] i_word,
    input  logic               i_send,
    input  logic               i_waiting,
    input  logic               i_tx_done,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_byte_done,
    output logic               o_word_done
);

    localparam int NB = INST_SZ / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [INST_SZ-1:0] shift_q, shift_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               last_byte;

    assign last_byte   = (idx_q == IW'(NB - 1));
    assign o_byte_done = i_waiting & i_tx_done;
    assign o_word_done = o_byte_done & last_byte;
    assign o_tx_start  = i_send;
    assign o_tx_data   = shift_q[INST_SZ-1 -: 8];

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (i_load) begin
            shift_d = i_word;
            idx_d   = '0;
        end else if (o_byte_done && !last_byte) begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + IW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: loads programs into instruction memory, runs or
// single-steps the pipeline, then dumps PC and the debug register space.
module debug_unit
    import debug_pkg::*;
#(
    parameter int INST_SZ    = 32,
    parameter int REG_SZ     = 5,
    parameter int DUMP_WORDS = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_write,
    output logic               o_enable,
    output logic [REG_SZ-1:0]  o_debug_addr,
    input  logic [INST_SZ-1:0] i_pc,
    input  logic [INST_SZ-1:0] i_data,
    input  logic               i_halt,
    output state_e             o_state
);

    // Word 0 of a dump is the PC; word k >= 1 is debug address k-1.
    localparam int WCNT_W = $clog2(DUMP_WORDS + 1);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [INST_SZ-1:0]  asm_q, asm_d;
    logic [REG_SZ-1:0]   addr_q, addr_d;
    logic [WCNT_W-1:0]   word_q, word_d;

    logic                tx_load, tx_send, tx_waiting;
    logic                byte_done, word_done;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: state_d = LOAD;
                        CMD_CONT: state_d = RUN;
                        CMD_STEP: state_d = STEP;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            LOAD: begin
                if (i_rx_done) begin
                    asm_d = {asm_q[INST_SZ-9:0], i_rx_data};
                    if (cnt_q == 2'd3) begin
                        cnt_d   = '0;
                        state_d = LOAD_WR;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            LOAD_WR: state_d = (asm_q == INST_SZ'(HALT_INSTR)) ? IDLE : LOAD;
            RUN: begin
                if (i_halt) begin
                    addr_d  = '0;
                    word_d  = '0;
                    state_d = DUMP_ADDR;
                end
            end
            STEP: begin
                addr_d  = '0;
                word_d  = '0;
                state_d = DUMP_ADDR;
            end
            DUMP_ADDR: state_d = DUMP_CAP;
            DUMP_CAP:  state_d = DUMP_SEND;
            DUMP_SEND: state_d = DUMP_WAIT;
            DUMP_WAIT: begin
                if (word_done) begin
                    if (word_q == WCNT_W'(DUMP_WORDS)) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = word_q + WCNT_W'(1);
                        if (word_q != '0) addr_d = addr_q + REG_SZ'(1);
                        state_d = DUMP_ADDR;
                    end
                end else if (byte_done) begin
                    state_d = DUMP_SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_write       = (state_q == LOAD_WR);
        o_enable      = ((state_q == RUN) || (state_q == STEP)) && !i_halt;
        o_instruction = asm_q;
        o_debug_addr  = addr_q;
        o_state       = state_q;
        tx_load       = (state_q == DUMP_CAP);
        tx_send       = (state_q == DUMP_SEND);
        tx_waiting    = (state_q == DUMP_WAIT);
    end

    debug_word_tx #(
        .INST_SZ (INST_SZ)
    ) u_word_tx (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (tx_load),
        .i_word      ((word_q == '0) ? i_pc : i_data),
        .i_send      (tx_send),
        .i_waiting   (tx_waiting),
        .i_tx_done   (i_tx_done),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_byte_done (byte_done),
        .o_word_done (word_done)
    );

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: randomized load/run/step/reset traffic checked every
// cycle against a byte-level model of what the host must see.
module tb_debug_unit;
  import debug_pkg::*;

  localparam int INST_SZ    = 32;
  localparam int REG_SZ     = 5;
  localparam int DUMP_WORDS = 32;
  localparam int DUMP_BYTES = 4 + 4 * DUMP_WORDS;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]         rx_data = '0;
  logic               rx_done = 1'b0;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_done = 1'b0;
  logic [INST_SZ-1:0] instr;
  logic               wr;
  logic               en;
  logic [REG_SZ-1:0]  dbg_addr;
  logic [INST_SZ-1:0] pc = '0;
  logic [INST_SZ-1:0] data;
  logic               halt = 1'b0;
  state_e             st;

  // pipeline register file model: word at address a is a*mul ^ salt
  logic [31:0] data_mul = 32'd3;
  logic [31:0] data_salt = 32'd0;
  assign data = 32'(dbg_addr) * data_mul ^ data_salt;

  debug_unit #(
    .INST_SZ    (INST_SZ),
    .REG_SZ     (REG_SZ),
    .DUMP_WORDS (DUMP_WORDS)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_rx_data     (rx_data),
    .i_rx_done     (rx_done),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .i_tx_done     (tx_done),
    .o_instruction (instr),
    .o_write       (wr),
    .o_enable      (en),
    .o_debug_addr  (dbg_addr),
    .i_pc          (pc),
    .i_data        (data),
    .i_halt        (halt),
    .o_state       (st)
  );

  // scoreboard
  logic [7:0]  exp_q[$];
  logic [31:0] exp_wr_q[$];
  logic [7:0]  tx_log[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          en_cnt = 0;
  int          tx_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_last = '0;
  bit          tx_busy = 1'b0;
  int          tx_cd = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // compare process plus transmitter responder
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (en) en_cnt++;
        if (wr) begin
          wr_cnt++;
          wr_last = instr;
          if (exp_wr_q.size() == 0) unexpected("unexpected_write", instr);
          else check("write_word", instr, exp_wr_q.pop_front());
        end
        if (tx_start) begin
          check("tx_start_while_busy", tx_busy, 1'b0);
          tx_cnt++;
          tx_log.push_back(tx_data);
          if (exp_q.size() == 0) unexpected("unexpected_tx_byte", tx_data);
          else check("tx_byte", tx_data, exp_q.pop_front());
          tx_busy = 1'b1;
          tx_cd   = $urandom_range(0, 3);
        end else if (tx_busy) begin
          if (tx_cd == 0) begin
            tx_done = 1'b1;
            tx_busy = 1'b0;
          end else begin
            tx_cd--;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1 rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    exp_wr_q.push_back(w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic push_dump();
    logic [31:0] w;
    for (int k = 3; k >= 0; k--) exp_q.push_back(pc[8*k +: 8]);
    for (int a = 0; a < DUMP_WORDS; a++) begin
      w = 32'(a) * data_mul ^ data_salt;
      for (int k = 3; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic wait_idle(input string name);
    int budget = 5000;
    while ((exp_q.size() != 0 || st != IDLE) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, "_dump_finished"}, budget > 0, 1'b1);
  endtask

  task automatic run_dump(input logic [7:0] cmd, input int run_cycles, input bit junk,
                          input int exp_en, input string name);
    en_cnt = 0;
    tx_cnt = 0;
    tx_log.delete();
    push_dump();
    send_byte(cmd);
    if (cmd == CMD_CONT) begin
      repeat (run_cycles) begin
        @(posedge clk);
        #1;
        if (junk) begin
          rx_done = 1'($urandom_range(0, 1));
          rx_data = 8'($urandom);
        end
      end
      halt = 1'b1;
      rx_done = 1'b0;
    end
    wait_idle(name);
    repeat (2) @(negedge clk);
    check({name, "_enable_cycles"}, en_cnt, exp_en);
    check({name, "_tx_bytes"}, tx_cnt, DUMP_BYTES);
    check({name, "_state_idle"}, st == IDLE, 1'b1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_start"}, tx_start, 1'b0);
    check({name, "_write"}, wr, 1'b0);
    check({name, "_enable"}, en, 1'b0);
    check({name, "_tx_data"}, tx_data, 8'h00);
    check({name, "_instruction"}, instr, 32'h0);
    check({name, "_debug_addr"}, dbg_addr, '0);
    check({name, "_state"}, st == IDLE, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    int budget;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // unknown command byte is ignored
    en_cnt = 0;
    send_byte(8'h41);
    @(negedge clk);
    check("ignore_0x41_state", st == IDLE, 1'b1);
    check("ignore_0x41_enable", en_cnt, 0);

    // single load word stays in LOAD
    send_byte(CMD_LOAD);
    load_word(32'h2002_0002);
    repeat (2) @(negedge clk);
    check("load_one_write_count", wr_cnt, 1);
    check("load_word_literal", wr_last, 32'h2002_0002);
    check("load_state_load", st == LOAD, 1'b1);

    // more random words, then HALT ends the load
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      if (w == HALT_INSTR) w = 32'h1;
      load_word(w);
    end
    load_word(HALT_INSTR);
    repeat (2) @(negedge clk);
    check("halt_write_literal", wr_last, 32'h0000_003F);
    check("halt_state_idle", st == IDLE, 1'b1);
    check("load_write_count", wr_cnt, 5);
    send_byte(8'h20);
    repeat (2) @(negedge clk);
    check("after_halt_0x20_idle", st == IDLE, 1'b1);
    check("writes_drained", exp_wr_q.size(), 0);

    // continue, halt after exactly 10 enabled cycles
    pc = 32'hDEAD_BEEF;
    data_mul = $urandom;
    data_salt = $urandom;
    run_dump(CMD_CONT, 10, 1'b0, 10, "cont10");
    check("cont10_pc_b0", tx_log[0], 8'hDE);
    check("cont10_pc_b1", tx_log[1], 8'hAD);
    check("cont10_pc_b2", tx_log[2], 8'hBE);
    check("cont10_pc_b3", tx_log[3], 8'hEF);
    halt = 1'b0;

    // single step with i_data = addr*3
    pc = $urandom;
    data_mul = 32'd3;
    data_salt = 32'd0;
    run_dump(CMD_STEP, 0, 1'b0, 1, "step");
    check("step_word7_b0", tx_log[32], 8'h00);
    check("step_word7_b1", tx_log[33], 8'h00);
    check("step_word7_b2", tx_log[34], 8'h00);
    check("step_word7_b3", tx_log[35], 8'h15);

    // continue with random receive traffic during RUN
    for (int i = 0; i < 2; i++) begin
      halt = 1'b0;
      pc = $urandom;
      data_mul = $urandom;
      data_salt = $urandom;
      n = $urandom_range(3, 20);
      run_dump(CMD_CONT, n, 1'b1, n, "cont_junk");
    end

    // commands issued with the pipeline already halted
    halt = 1'b1;
    pc = $urandom;
    run_dump(CMD_CONT, 0, 1'b0, 0, "cont_halted");
    run_dump(CMD_STEP, 0, 1'b0, 0, "step_halted");
    halt = 1'b0;

    // reset during the third dump byte, then a full fresh dump
    pc = $urandom;
    data_mul = $urandom;
    tx_cnt = 0;
    push_dump();
    send_byte(CMD_STEP);
    budget = 2000;
    while (tx_cnt < 3 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("reset_mid_dump_reached", budget > 0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("reset_next_edge");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    pc = $urandom;
    run_dump(CMD_STEP, 0, 1'b0, 1, "step_after_reset");

    // load still works after dumps
    send_byte(CMD_LOAD);
    load_word($urandom | 32'h100);
    load_word(HALT_INSTR);
    repeat (2) @(negedge clk);
    check("reload_state_idle", st == IDLE, 1'b1);
    check("reload_writes_drained", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
